// File: rtl/ticker.sv
// Prescaled timer/counter with a compare-match flag and a small register
// interface for a data bus.
//
// Ports:
//   clk                    sole clock, all state updates on the rising edge
//   rst                    synchronous active-high reset
//   ticker_addr            byte offset into the register map (bits [1:0] ignored)
//   write_data_to_ticker   write data
//   ticker_write_enable    single-cycle write strobe
//   ticker_read_enable     read strobe (no side effects)
//   read_data_from_ticker  register read data, combinational from the address
//   ticker_irq             level interrupt, match flag gated by interrupt enable
//
// Register map (word offsets): 0x00 COUNT, 0x04 COMPARE, 0x08 CTRL {AR,IE,EN},
// 0x0C PRESCALE[15:0], 0x10 STATUS {MF} (write 1 to clear).
module ticker #(
  parameter logic [15:0] PRESCALE_RST = 16'd0,
  parameter int unsigned COUNT_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ticker_addr,
  input  logic [31:0] write_data_to_ticker,
  input  logic        ticker_write_enable,
  input  logic        ticker_read_enable,
  output logic [31:0] read_data_from_ticker,
  output logic        ticker_irq
);

  localparam logic [5:0] A_COUNT    = 6'h00;
  localparam logic [5:0] A_COMPARE  = 6'h01;
  localparam logic [5:0] A_CTRL     = 6'h02;
  localparam logic [5:0] A_PRESCALE = 6'h03;
  localparam logic [5:0] A_STATUS   = 6'h04;

  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_compare;
  logic [2:0]             r_ctrl;      // {AR, IE, EN}
  logic [15:0]            r_prescale;
  logic [15:0]            r_pc;
  logic                   r_mf;

  logic [5:0]             w_word;
  logic                   w_wr_count;
  logic                   w_wr_compare;
  logic                   w_wr_ctrl;
  logic                   w_wr_prescale;
  logic                   w_wr_status;
  logic                   w_tick;
  logic                   w_match;
  logic [COUNT_WIDTH-1:0] w_wdata_cnt;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   w_unused;

  assign w_word        = ticker_addr[7:2];
  assign w_wr_count    = ticker_write_enable && (w_word == A_COUNT);
  assign w_wr_compare  = ticker_write_enable && (w_word == A_COMPARE);
  assign w_wr_ctrl     = ticker_write_enable && (w_word == A_CTRL);
  assign w_wr_prescale = ticker_write_enable && (w_word == A_PRESCALE);
  assign w_wr_status   = ticker_write_enable && (w_word == A_STATUS);
  assign w_wdata_cnt   = write_data_to_ticker[COUNT_WIDTH-1:0];

  // Tick and match are judged on pre-write state, so same-cycle writes
  // never suppress or fabricate an event.
  assign w_tick       = r_ctrl[0] && (r_pc == r_prescale);
  assign w_match      = w_tick && (r_count == r_compare);
  assign w_count_next = (w_match && r_ctrl[2]) ? '0 : r_count + COUNT_WIDTH'(1);

  // Read strobe and byte-lane bits carry no information for this block.
  assign w_unused = ^{ticker_read_enable, ticker_addr[1:0], write_data_to_ticker};

  // Register state update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_compare  <= '1;
      r_ctrl     <= 3'b000;
      r_prescale <= PRESCALE_RST;
      r_pc       <= 16'd0;
      r_mf       <= 1'b0;
    end else begin
      if (w_wr_count) begin
        r_count <= w_wdata_cnt;
      end else if (w_tick) begin
        r_count <= w_count_next;
      end

      if (w_wr_compare) begin
        r_compare <= w_wdata_cnt;
      end

      if (w_wr_ctrl) begin
        r_ctrl <= write_data_to_ticker[2:0];
      end

      // A new prescale value restarts the prescaler phase.
      if (w_wr_prescale) begin
        r_prescale <= write_data_to_ticker[15:0];
        r_pc       <= 16'd0;
      end else if (r_ctrl[0]) begin
        r_pc <= w_tick ? 16'd0 : r_pc + 16'd1;
      end

      // A match in the same cycle beats a software clear.
      if (w_match) begin
        r_mf <= 1'b1;
      end else if (w_wr_status && write_data_to_ticker[0]) begin
        r_mf <= 1'b0;
      end
    end
  end

  // Zero-wait read mux.
  always_comb begin
    read_data_from_ticker = 32'd0;
    case (w_word)
      A_COUNT:    read_data_from_ticker = 32'(r_count);
      A_COMPARE:  read_data_from_ticker = 32'(r_compare);
      A_CTRL:     read_data_from_ticker = {29'd0, r_ctrl};
      A_PRESCALE: read_data_from_ticker = {16'd0, r_prescale};
      A_STATUS:   read_data_from_ticker = {31'd0, r_mf};
      default:    read_data_from_ticker = 32'd0;
    endcase
  end

  assign ticker_irq = r_mf & r_ctrl[1];

endmodule
